// File: rtl/limiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | limiter_pkg : shared types for the time-multiplexed track limiter  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package limiter_pkg;

  localparam int LIM_W = 16;

  localparam logic LIM_HARD = 1'b0;
  localparam logic LIM_SOFT = 1'b1;

  // Positive full scale: the limiter is transparent until a track is configured.
  localparam logic [LIM_W-1:0] LIM_DEFAULT_LIMIT = 16'h7FFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic             enable;
    logic             ltype;
    logic [LIM_W-1:0] limit;
  } lim_cfg_t;

endpackage
`default_nettype wire

// File: rtl/limiter_cfg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | limiter_cfg_bank : per-track limiter settings, one write port and  |
// | a snapshot-all read port. Rev 1.0                                  |
// +--------------------------------------------------------------------+
module limiter_cfg_bank
  import limiter_pkg::*;
#(
  parameter int NUM_TRACKS = 4,
  parameter int IDX_W      = $clog2(NUM_TRACKS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [IDX_W-1:0]            track,
  input  lim_cfg_t                    wr_cfg,
  output lim_cfg_t [NUM_TRACKS-1:0]   bank
);

  localparam logic [IDX_W:0] TRACK_COUNT = (IDX_W + 1)'(NUM_TRACKS);

  logic in_range;

  assign in_range = ({1'b0, track} < TRACK_COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TRACKS; i++) begin
        bank[i] <= '{enable: 1'b0, ltype: LIM_HARD, limit: LIM_DEFAULT_LIMIT};
      end
    end else if (we && in_range) begin
      bank[track] <= wr_cfg;
    end
  end

endmodule
`default_nettype wire

// File: rtl/limiter_track_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | limiter_track_scheduler : shares one stereo limiter across all     |
// | mixer tracks, one track per cycle, per sample strobe. Rev 1.0      |
// +--------------------------------------------------------------------+
module limiter_track_scheduler
  import limiter_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int NUM_TRACKS  = 4,
  parameter int LIM_LATENCY = 1
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          sample_strobe,
  input  logic [NUM_TRACKS*WIDTH-1:0]   trk_l_in,
  input  logic [NUM_TRACKS*WIDTH-1:0]   trk_r_in,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_TRACKS)-1:0] cfg_track,
  input  logic                          cfg_enable,
  input  logic                          cfg_type,
  input  logic [WIDTH-1:0]              cfg_limit,
  output logic                          lim_enable,
  output logic                          lim_type,
  output logic [WIDTH-1:0]              lim_limit,
  output logic [WIDTH-1:0]              lim_dry_l,
  output logic [WIDTH-1:0]              lim_dry_r,
  input  logic [WIDTH-1:0]              lim_wet_l,
  input  logic [WIDTH-1:0]              lim_wet_r,
  output logic [NUM_TRACKS*WIDTH-1:0]   out_l,
  output logic [NUM_TRACKS*WIDTH-1:0]   out_r,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int IDX_W = $clog2(NUM_TRACKS);

  if (WIDTH != LIM_W) begin : g_width_check
    $error("WIDTH must match limiter_pkg::LIM_W");
  end

  sched_state_t               state;
  sched_state_t               state_nx;
  lim_cfg_t [NUM_TRACKS-1:0]  bank;
  lim_cfg_t [NUM_TRACKS-1:0]  snap_cfg;
  lim_cfg_t                   wr_cfg;
  lim_cfg_t                   issue_cfg;
  lim_cfg_t                   held_cfg;
  logic [NUM_TRACKS*WIDTH-1:0] snap_l;
  logic [NUM_TRACKS*WIDTH-1:0] snap_r;
  logic [WIDTH-1:0]           issue_l;
  logic [WIDTH-1:0]           issue_r;
  logic [WIDTH-1:0]           held_l;
  logic [WIDTH-1:0]           held_r;
  logic [IDX_W-1:0]           issue_idx;
  logic [LIM_LATENCY-1:0]     pipe_vld;
  logic [IDX_W-1:0]           pipe_idx [LIM_LATENCY];
  logic                       accept;
  logic                       issuing;
  logic                       last_issue;
  logic                       pending;

  assign wr_cfg = '{enable: cfg_enable, ltype: cfg_type, limit: cfg_limit};

  limiter_cfg_bank #(
    .NUM_TRACKS (NUM_TRACKS),
    .IDX_W      (IDX_W)
  ) u_cfg_bank (
    .clk    (clk_in),
    .rst_n  (rst_in),
    .we     (cfg_we),
    .track  (cfg_track),
    .wr_cfg (wr_cfg),
    .bank   (bank)
  );

  always_comb begin
    accept     = (state == IDLE) && sample_strobe;
    issuing    = (state == ISSUE);
    last_issue = (issue_idx == IDX_W'(NUM_TRACKS - 1));
    issue_cfg  = snap_cfg[issue_idx];
    issue_l    = snap_l[issue_idx*WIDTH +: WIDTH];
    issue_r    = snap_r[issue_idx*WIDTH +: WIDTH];

    // The final stage retires on this edge, so only earlier stages hold DONE back.
    pending = 1'b0;
    for (int k = 0; k < LIM_LATENCY - 1; k++) begin
      pending = pending | pipe_vld[k];
    end

    state_nx = state;
    unique case (state)
      IDLE:    if (sample_strobe) state_nx = ISSUE;
      ISSUE:   if (last_issue)    state_nx = DRAIN;
      DRAIN:   if (!pending)      state_nx = DONE;
      DONE:                       state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  assign lim_enable = issuing ? issue_cfg.enable : held_cfg.enable;
  assign lim_type   = issuing ? issue_cfg.ltype  : held_cfg.ltype;
  assign lim_limit  = issuing ? issue_cfg.limit  : held_cfg.limit;
  assign lim_dry_l  = issuing ? issue_l          : held_l;
  assign lim_dry_r  = issuing ? issue_r          : held_r;
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      snap_cfg  <= '0;
      snap_l    <= '0;
      snap_r    <= '0;
      issue_idx <= '0;
      held_cfg  <= '0;
      held_l    <= '0;
      held_r    <= '0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        snap_cfg  <= bank;
        snap_l    <= trk_l_in;
        snap_r    <= trk_r_in;
        issue_idx <= '0;
      end else if (issuing) begin
        issue_idx <= issue_idx + 1'b1;
      end
      if (issuing) begin
        held_cfg <= issue_cfg;
        held_l   <= issue_l;
        held_r   <= issue_r;
      end
      if (sample_strobe && !accept) begin
        overrun <= 1'b1;
      end
    end
  end

  // Issue tracker: each stage carries the track index the limiter is working on.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pipe_vld <= '0;
      for (int k = 0; k < LIM_LATENCY; k++) begin
        pipe_idx[k] <= '0;
      end
      out_l <= '0;
      out_r <= '0;
    end else begin
      pipe_vld[0] <= issuing;
      pipe_idx[0] <= issue_idx;
      for (int k = 1; k < LIM_LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_idx[k] <= pipe_idx[k-1];
      end
      if (pipe_vld[LIM_LATENCY-1]) begin
        out_l[pipe_idx[LIM_LATENCY-1]*WIDTH +: WIDTH] <= lim_wet_l;
        out_r[pipe_idx[LIM_LATENCY-1]*WIDTH +: WIDTH] <= lim_wet_r;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_limiter_track_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_limiter_track_scheduler : scoreboard bench for two scheduler    |
// | configurations (4 tracks/latency 1, 8 tracks/latency 3). Rev 1.0   |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_limiter_track_scheduler;

  localparam int W  = 16;
  localparam int NA = 4;
  localparam int LA = 1;
  localparam int NB = 8;
  localparam int LB = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic            a_strobe = 1'b0, a_we = 1'b0, a_en = 1'b0, a_ty = 1'b0;
  logic [1:0]      a_trk = '0;
  logic [W-1:0]    a_lim = '0;
  logic [NA*W-1:0] a_l = '0, a_r = '0, a_out_l, a_out_r;
  logic            a_lim_en, a_lim_ty, a_valid, a_busy, a_ovr;
  logic [W-1:0]    a_lim_lim, a_dry_l, a_dry_r;
  logic [W-1:0]    a_wet_l = '0, a_wet_r = '0;

  logic            b_strobe = 1'b0, b_we = 1'b0, b_en = 1'b0, b_ty = 1'b0;
  logic [2:0]      b_trk = '0;
  logic [W-1:0]    b_lim = '0;
  logic [NB*W-1:0] b_l = '0, b_r = '0, b_out_l, b_out_r;
  logic            b_lim_en, b_lim_ty, b_valid, b_busy, b_ovr;
  logic [W-1:0]    b_lim_lim, b_dry_l, b_dry_r;
  logic [W-1:0]    b_wet_l = '0, b_wet_r = '0;
  logic [W-1:0]    b_p1l = '0, b_p1r = '0, b_p2l = '0, b_p2r = '0;

  limiter_track_scheduler #(.WIDTH(W), .NUM_TRACKS(NA), .LIM_LATENCY(LA)) dut_a (
    .clk_in(clk), .rst_in(rst_n), .sample_strobe(a_strobe),
    .trk_l_in(a_l), .trk_r_in(a_r),
    .cfg_we(a_we), .cfg_track(a_trk), .cfg_enable(a_en), .cfg_type(a_ty), .cfg_limit(a_lim),
    .lim_enable(a_lim_en), .lim_type(a_lim_ty), .lim_limit(a_lim_lim),
    .lim_dry_l(a_dry_l), .lim_dry_r(a_dry_r), .lim_wet_l(a_wet_l), .lim_wet_r(a_wet_r),
    .out_l(a_out_l), .out_r(a_out_r), .out_valid(a_valid), .busy(a_busy), .overrun(a_ovr)
  );

  limiter_track_scheduler #(.WIDTH(W), .NUM_TRACKS(NB), .LIM_LATENCY(LB)) dut_b (
    .clk_in(clk), .rst_in(rst_n), .sample_strobe(b_strobe),
    .trk_l_in(b_l), .trk_r_in(b_r),
    .cfg_we(b_we), .cfg_track(b_trk), .cfg_enable(b_en), .cfg_type(b_ty), .cfg_limit(b_lim),
    .lim_enable(b_lim_en), .lim_type(b_lim_ty), .lim_limit(b_lim_lim),
    .lim_dry_l(b_dry_l), .lim_dry_r(b_dry_r), .lim_wet_l(b_wet_l), .lim_wet_r(b_wet_r),
    .out_l(b_out_l), .out_r(b_out_r), .out_valid(b_valid), .busy(b_busy), .overrun(b_ovr)
  );

  // Behavioural limiter: hard clamps to +/-limit, soft halves the excess.
  function automatic logic [W-1:0] limf(logic en, logic ty, logic [W-1:0] lim, logic [W-1:0] x);
    int xi, li, y;
    xi = int'($signed(x));
    li = int'($signed(lim));
    if (!en)           y = xi;
    else if (xi > li)  y = ty ? (li + xi) / 2 : li;
    else if (xi < -li) y = ty ? (xi - li) / 2 : -li;
    else               y = xi;
    return W'(y);
  endfunction

  always @(posedge clk) begin
    a_wet_l <= limf(a_lim_en, a_lim_ty, a_lim_lim, a_dry_l);
    a_wet_r <= limf(a_lim_en, a_lim_ty, a_lim_lim, a_dry_r);
    b_p1l   <= limf(b_lim_en, b_lim_ty, b_lim_lim, b_dry_l);
    b_p1r   <= limf(b_lim_en, b_lim_ty, b_lim_lim, b_dry_r);
    b_p2l   <= b_p1l;
    b_p2r   <= b_p1r;
    b_wet_l <= b_p2l;
    b_wet_r <= b_p2r;
  end

  typedef struct {
    logic [127:0] l;
    logic [127:0] r;
    int           cyc;
  } exp_t;

  exp_t         qa[$];
  exp_t         qb[$];
  int           errors = 0;
  int           checks = 0;
  logic         en_m  [2][8];
  logic         ty_m  [2][8];
  logic [W-1:0] lim_m [2][8];

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && a_valid) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_valid: got out_valid required none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_out_l", 128'(a_out_l), e.l);
        check("a_out_r", 128'(a_out_r), e.r);
        check("a_latency", 128'(cyc - e.cyc), 128'(NA + LA + 1));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_valid) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_valid: got out_valid required none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_out_l", 128'(b_out_l), e.l);
        check("b_out_r", 128'(b_out_r), e.r);
        check("b_latency", 128'(cyc - e.cyc), 128'(NB + LB + 1));
      end
    end
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 8; t++) begin
        en_m[d][t]  = 1'b0;
        ty_m[d][t]  = 1'b0;
        lim_m[d][t] = 16'h7FFF;
      end
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One cycle of stimulus to DUT d; the expected frame uses the config in force before this edge.
  task automatic drive(int d, bit s, bit push, logic [127:0] l, logic [127:0] r,
                       bit we, int t, bit en, bit ty, logic [W-1:0] lim);
    exp_t e;
    int   n;
    n = (d == 0) ? NA : NB;
    if (s && push) begin
      e.l   = '0;
      e.r   = '0;
      e.cyc = cyc;
      for (int i = 0; i < n; i++) begin
        e.l[i*W +: W] = limf(en_m[d][i], ty_m[d][i], lim_m[d][i], l[i*W +: W]);
        e.r[i*W +: W] = limf(en_m[d][i], ty_m[d][i], lim_m[d][i], r[i*W +: W]);
      end
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
    if (d == 0) begin
      a_strobe = s; a_we = we; a_trk = 2'(t); a_en = en; a_ty = ty; a_lim = lim;
      if (s) begin a_l = l[NA*W-1:0]; a_r = r[NA*W-1:0]; end
    end else begin
      b_strobe = s; b_we = we; b_trk = 3'(t); b_en = en; b_ty = ty; b_lim = lim;
      if (s) begin b_l = l[NB*W-1:0]; b_r = r[NB*W-1:0]; end
    end
    @(posedge clk);
    #1;
    a_strobe = 1'b0; a_we = 1'b0;
    b_strobe = 1'b0; b_we = 1'b0;
    if (we) begin
      en_m[d][t]  = en;
      ty_m[d][t]  = ty;
      lim_m[d][t] = lim;
    end
  endtask

  task automatic tick(int d, int n);
    for (int k = 0; k < n; k++) drive(d, 1'b0, 1'b0, '0, '0, 1'b0, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic wr(int d, int t, bit en, bit ty, logic [W-1:0] lim);
    drive(d, 1'b0, 1'b0, '0, '0, 1'b1, t, en, ty, lim);
  endtask

  task automatic frame(int d, logic [127:0] l, logic [127:0] r, bit push);
    drive(d, 1'b1, push, l, r, 1'b0, 0, 1'b0, 1'b0, '0);
  endtask

  // Strobe at the earliest legal cycle after the previous frame, with random config traffic.
  task automatic rand_frame(int d);
    int n, span;
    n    = (d == 0) ? NA : NB;
    span = (d == 0) ? NA + LA + 2 : NB + LB + 2;
    drive(d, 1'b1, 1'b1, rand128(), rand128(), 1'($urandom_range(0, 1)),
          $urandom_range(0, n - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          W'($urandom_range(1, 32767)));
    for (int k = 1; k < span; k++) begin
      drive(d, 1'b0, 1'b0, '0, '0, ($urandom_range(0, 2) == 0), $urandom_range(0, n - 1),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom_range(1, 32767)));
    end
  endtask

  initial begin
    logic [127:0] vl, vr;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(a_valid), 128'(0));
    check("rst_busy", 128'(a_busy), 128'(0));
    check("rst_overrun", 128'(a_ovr), 128'(0));
    check("rst_out_l", 128'(a_out_l), 128'(0));
    check("rst_lim_limit", 128'(a_lim_lim), 128'(0));
    check("rst_b_out_r", 128'(b_out_r), 128'(0));
    rst_n = 1'b1;
    tick(0, 2);

    // Hard limit on track 0
    wr(0, 0, 1'b1, 1'b0, 16'd1000);
    vl = rand128(); vr = rand128();
    vl[15:0] = 16'd3000; vr[15:0] = 16'hF448;
    frame(0, vl, vr, 1'b1);
    check("busy_in_frame", 128'(a_busy), 128'(1));
    tick(0, 6);
    check("hard_out_l0", 128'(a_out_l[15:0]), 128'(16'd1000));
    check("hard_out_r0", 128'(a_out_r[15:0]), 128'(16'hFC18));

    // Per-track independence
    wr(0, 1, 1'b0, 1'b0, 16'd50);
    wr(0, 2, 1'b1, 1'b0, 16'd500);
    vl = rand128(); vr = rand128();
    vl[31:16] = 16'd20000; vr[47:32] = 16'd600;
    frame(0, vl, vr, 1'b1);
    tick(0, 6);
    check("indep_out_l1", 128'(a_out_l[31:16]), 128'(16'd20000));
    check("indep_out_r2", 128'(a_out_r[47:32]), 128'(16'd500));

    // Mid-frame config write lands only in the following frame
    wr(0, 3, 1'b1, 1'b0, 16'd30000);
    vl = rand128(); vr = rand128();
    vl[63:48] = 16'd5000; vr[63:48] = 16'd5000;
    frame(0, vl, vr, 1'b1);
    tick(0, 1);
    wr(0, 3, 1'b1, 1'b0, 16'd100);
    tick(0, 4);
    check("midcfg_frame_n", 128'(a_out_l[63:48]), 128'(16'd5000));
    frame(0, vl, vr, 1'b1);
    tick(0, 6);
    check("midcfg_frame_n1_l", 128'(a_out_l[63:48]), 128'(16'd100));
    check("midcfg_frame_n1_r", 128'(a_out_r[63:48]), 128'(16'd100));

    repeat (25) rand_frame(0);

    // Eight tracks, latency three: ramp through pass-through config
    vl = '0; vr = '0;
    for (int i = 0; i < NB; i++) begin
      vl[i*W +: W] = W'(i * 1000 + 7);
      vr[i*W +: W] = W'(-(i * 1000 + 7));
    end
    frame(1, vl, vr, 1'b1);
    tick(1, 12);
    check("ramp_b_l7", 128'(b_out_l[127:112]), 128'(16'd7007));
    repeat (8) rand_frame(1);

    // Overrun: second strobe while busy is dropped
    check("pre_overrun", 128'(a_ovr), 128'(0));
    frame(0, rand128(), rand128(), 1'b1);
    tick(0, 2);
    frame(0, rand128(), rand128(), 1'b0);
    tick(0, 3);
    check("overrun_set", 128'(a_ovr), 128'(1));
    tick(0, 4);
    check("overrun_sticky", 128'(a_ovr), 128'(1));

    // Reset in the middle of ISSUE
    frame(0, rand128(), rand128(), 1'b0);
    tick(0, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_l", 128'(a_out_l), 128'(0));
    check("midrst_out_r", 128'(a_out_r), 128'(0));
    check("midrst_valid", 128'(a_valid), 128'(0));
    check("midrst_busy", 128'(a_busy), 128'(0));
    check("midrst_overrun", 128'(a_ovr), 128'(0));
    check("midrst_lim_limit", 128'(a_lim_limit_or_zero()), 128'(0));
    check("midrst_dry_l", 128'(a_dry_l), 128'(0));
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(0, 2);
    wr(0, 0, 1'b1, 1'b1, 16'd2000);
    frame(0, rand128(), rand128(), 1'b1);
    tick(0, 6);
    rand_frame(0);

    tick(0, 5);
    check("a_queue_drained", 128'(qa.size()), 128'(0));
    check("b_queue_drained", 128'(qb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [W-1:0] a_lim_limit_or_zero();
    return a_lim_lim;
  endfunction

endmodule
`default_nettype wire

// File: doc/limiter_track_scheduler.md
Name: limiter_track_scheduler

Overview:
- Time-multiplexes one shared stereo limiter instance across NUM_TRACKS mixer tracks.
- On each audio sample strobe, latches all track samples and per-track limiter settings, then issues each track to the limiter one per cycle.
- Captures the limited results and presents a complete output frame with a one-cycle valid pulse.
- Sits between the track sources and the master mixer in the 11.29 MHz audio domain.

Parameters:
- WIDTH, 16: sample and limit width; signed two's complement.
- NUM_TRACKS, 4: number of tracks sharing the limiter; must be at least 2.
- LIM_LATENCY, 1: cycles from driving lim_dry_* to the matching lim_wet_*; must be at least 1.

Ports:
- clk_in  input  1  system clock, 11.29 MHz.
- rst_in  input  1  asynchronous, active-low reset.
- sample_strobe  input  1  one-cycle pulse, once per audio sample period.
- trk_l_in  input  NUM_TRACKS*WIDTH  left samples; track i occupies bits [i*WIDTH +: WIDTH].
- trk_r_in  input  NUM_TRACKS*WIDTH  right samples; same packing as trk_l_in.
- cfg_we  input  1  configuration write strobe.
- cfg_track  input  $clog2(NUM_TRACKS)  track index for the write.
- cfg_enable  input  1  limiter enable for the track.
- cfg_type  input  1  limiter type for the track: 0 = hard, 1 = soft.
- cfg_limit  input  WIDTH  threshold for the track, positive.
- lim_enable  output  1  enable to the shared limiter.
- lim_type  output  1  type to the shared limiter.
- lim_limit  output  WIDTH  threshold to the shared limiter.
- lim_dry_l  output  WIDTH  left sample to the shared limiter.
- lim_dry_r  output  WIDTH  right sample to the shared limiter.
- lim_wet_l  input  WIDTH  left result from the shared limiter.
- lim_wet_r  input  WIDTH  right result from the shared limiter.
- out_l  output  NUM_TRACKS*WIDTH  limited left frame; same packing as trk_l_in.
- out_r  output  NUM_TRACKS*WIDTH  limited right frame; same packing as trk_r_in.
- out_valid  output  1  one-cycle pulse when the frame is complete.
- busy  output  1  high while a frame is in flight.
- overrun  output  1  sticky; set when sample_strobe arrives while busy.

Behaviour:
- Reset (asynchronous, rst_in low):
  - All outputs go to 0: frame, lim_*, out_valid, busy, overrun.
  - State returns to IDLE.
  - Config bank resets to enable=0, type=0, limit=16'h7FFF (positive full scale for the default width) for every track.
- Config bank:
  - On cfg_we, the cfg_* values are written to track cfg_track in the next cycle.
  - Writes to an out-of-range index are ignored.
  - Writes are always accepted, including while busy, but take effect only at the next frame start.
- State machine: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - On sample_strobe, snapshot trk_l_in, trk_r_in and the entire config bank into frame registers.
  - Clear issue_idx; set busy. Next state is ISSUE.
- ISSUE:
  - Each cycle, drive lim_dry_l, lim_dry_r, lim_enable, lim_type and lim_limit from snapshot entry issue_idx, then increment issue_idx.
  - After issuing index NUM_TRACKS-1, go to DRAIN.
- Capture:
  - A LIM_LATENCY-deep valid/index shift register tracks every issue.
  - When its output is valid, lim_wet_l and lim_wet_r are written into out_l and out_r at the delayed index.
  - Capture runs concurrently with issue.
- DRAIN: wait until the shift register is empty, then go to DONE.
- DONE:
  - Pulse out_valid for exactly one cycle and clear busy. Next state is IDLE.
  - out_l and out_r hold their values until the next frame's captures overwrite them.
- Latency: out_valid asserts exactly NUM_TRACKS + LIM_LATENCY + 1 cycles after the strobe cycle.
  - With the defaults that is 6 cycles; the cycle budget per sample (~256) is ample.
- Idle drive: lim_* outputs hold their last issued values outside ISSUE; the limiter result is ignored then.
- Overrun:
  - sample_strobe while busy, or in the DONE cycle, is ignored for frame start and sets overrun.
  - overrun clears only on reset.
- Simultaneous events: cfg_we in the same cycle as the accepted sample_strobe is not included in that frame's snapshot.
- Reset mid-frame: the frame is abandoned, no out_valid is produced, and outputs are cleared.
- Arithmetic: pure routing. No sample arithmetic; values pass bit-exact.

Decomposition:
- Package limiter_pkg holds:
  - the state enum typedef (IDLE, ISSUE, DRAIN, DONE);
  - the packed struct lim_cfg_t {enable, type, limit};
  - localparams LIM_HARD=0, LIM_SOFT=1 and the default limit constant.
- Sub-module limiter_cfg_bank: the NUM_TRACKS-entry lim_cfg_t register file with a write port and a snapshot-all output. It is natural to separate; the scheduler instantiates it.

Test Plan:
- Basic hard limit: track 0 limit 1000, enable=1, type=0; drive samples L=3000, R=-3000 with a behavioural limiter model. Required: out_l[0]=1000, out_r[0]=-1000, out_valid exactly 6 cycles after strobe.
- Per-track independence: track 1 enable=0 with L=20000, track 2 limit 500 with R=600. Required: out_l[1]=20000, out_r[2]=500, remaining tracks unchanged.
- Mid-frame config: write track 3 limit=100 two cycles after the strobe, input 5000. Required: frame N uses the old limit; frame N+1 output is 100.
- Overrun: second strobe 3 cycles after the first. Required: overrun=1, a single out_valid, frame data from the first strobe only.
- Reset mid-frame: assert rst_in low in the ISSUE state. Required: outputs 0 immediately, no out_valid; after release a normal frame completes.
- Latency sweep: LIM_LATENCY=3, NUM_TRACKS=8 with indexed ramp inputs. Required: every track captured at its correct index, out_valid at cycle 12.
